// File: rtl/load_store_execution_unit_pkg.sv
// Shared types for the load-store execution path.
// Provides the memory action/size encodings, the scheduler entry layout offered by the
// load-store queue, and a helper that flags naturally misaligned accesses.
package load_store_execution_unit_pkg;

    localparam int unsigned PhysRegCount = 64;
    localparam int unsigned PregW        = $clog2(PhysRegCount);
    localparam int unsigned PcW          = 32;
    localparam int unsigned ImmW         = 12;

    typedef enum logic {
        MemRead  = 1'b0,
        MemWrite = 1'b1
    } mem_action_t;

    typedef enum logic [1:0] {
        MemByte = 2'd0,
        MemHalf = 2'd1,
        MemWord = 2'd2
    } mem_size_t;

    typedef struct packed {
        logic [PcW-1:0]   pc;
        mem_action_t      mem_action;
        mem_size_t        mem_size;
        logic             mem_signed;
        logic             uses_dst;
        logic [PregW-1:0] dst;
        logic [PregW-1:0] src1;
        logic [PregW-1:0] src2;
        logic [ImmW-1:0]  imm;
    } scheduler_entry_t;

    // Unused encoding 2'd3 is treated as a word access everywhere.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MemByte: mis = 1'b0;
            MemHalf: mis = addr_lo[0];
            default: mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering for the load-store unit.
// Store direction: builds byte enables and lane-replicated write data from size and the
// low address bits. Load direction: shifts the returned word down to the addressed lane
// and zero- or sign-extends bytes and halves.
//   i_size, i_signed, i_addr_lo   access descriptor
//   i_store_data -> o_be, o_wdata store lanes
//   i_load_data  -> o_load_data   aligned, extended load result
module lsu_data_align
    import load_store_execution_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned LaneW = $clog2(DATA_W / 8)
) (
    input  mem_size_t           i_size,
    input  logic                i_signed,
    input  logic [LaneW-1:0]    i_addr_lo,
    input  logic [DATA_W-1:0]   i_store_data,
    input  logic [DATA_W-1:0]   i_load_data,
    output logic [DATA_W/8-1:0] o_be,
    output logic [DATA_W-1:0]   o_wdata,
    output logic [DATA_W-1:0]   o_load_data
);

    localparam int Lanes = DATA_W / 8;

    logic [DATA_W-1:0] shifted;

    always_comb begin
        o_be    = '0;
        o_wdata = '0;
        for (int i = 0; i < Lanes; i++) begin
            case (i_size)
                MemByte: begin
                    o_be[i]          = (i == int'(i_addr_lo));
                    o_wdata[8*i +: 8] = i_store_data[7:0];
                end
                MemHalf: begin
                    o_be[i]          = (i >= int'(i_addr_lo)) && (i < int'(i_addr_lo) + 2);
                    o_wdata[8*i +: 8] = i_store_data[8*(i%2) +: 8];
                end
                default: begin
                    o_be[i]          = 1'b1;
                    o_wdata[8*i +: 8] = i_store_data[8*i +: 8];
                end
            endcase
        end
    end

    always_comb begin
        shifted = i_load_data >> {i_addr_lo, 3'b000};
        case (i_size)
            MemByte: o_load_data = {{(DATA_W-8){i_signed & shifted[7]}}, shifted[7:0]};
            MemHalf: o_load_data = {{(DATA_W-16){i_signed & shifted[15]}}, shifted[15:0]};
            default: o_load_data = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_execution_unit.sv
// Load-store execution unit: consumer of the load-store queue issue handshake.
// Takes one memory instruction at a time, computes its address from the base operand and
// immediate, issues a valid/ready request to the data cache, waits for load data, then
// writes back the destination register and reports completion to commit.
//   clk, rst_n                 clock, synchronous active-low reset
//   i_flush                    hazard flush; cancels in-flight loads, suppresses outputs
//   i_want_to_execute/o_take   queue offer / accept, i_next_to_execute is the entry
//   o_rf_raddr*/i_rf_rdata*    combinational register-file read of the offered entry
//   o_mem_req_*/i_mem_req_ready  cache request channel
//   i_mem_resp_*               load response for the outstanding read
//   o_wb_*                     destination register writeback
//   o_done_*                   completion report to the commit queue
//   o_busy                     unit is not idle
module load_store_execution_unit
    import load_store_execution_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_want_to_execute,
    input  scheduler_entry_t     i_next_to_execute,
    output logic                 o_take,
    output logic [PregW-1:0]     o_rf_raddr1,
    output logic [PregW-1:0]     o_rf_raddr2,
    input  logic [DATA_W-1:0]    i_rf_rdata1,
    input  logic [DATA_W-1:0]    i_rf_rdata2,
    output logic                 o_mem_req_valid,
    input  logic                 i_mem_req_ready,
    output logic                 o_mem_req_write,
    output logic [ADDR_W-1:0]    o_mem_req_addr,
    output logic [DATA_W-1:0]    o_mem_req_wdata,
    output logic [DATA_W/8-1:0]  o_mem_req_be,
    input  logic                 i_mem_resp_valid,
    input  logic [DATA_W-1:0]    i_mem_resp_data,
    output logic                 o_wb_valid,
    output logic [PregW-1:0]     o_wb_dst,
    output logic [DATA_W-1:0]    o_wb_data,
    output logic                 o_done_valid,
    output logic [ADDR_W-1:0]    o_done_pc,
    output logic                 o_done_misaligned,
    output logic                 o_busy
);

    localparam int unsigned LaneW = $clog2(DATA_W / 8);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StDone,
        StDrain
    } lsu_state_t;

    lsu_state_t          state_q, state_d;
    logic [PcW-1:0]      pc_q, pc_d;
    mem_action_t         action_q, action_d;
    mem_size_t           size_q, size_d;
    logic                signed_q, signed_d;
    logic                uses_dst_q, uses_dst_d;
    logic [PregW-1:0]    dst_q, dst_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic                misaligned_q, misaligned_d;
    logic [DATA_W-1:0]   ldata_q, ldata_d;

    logic [ADDR_W-1:0]   addr_calc;
    logic                take;
    logic [DATA_W/8-1:0] align_be;
    logic [DATA_W-1:0]   align_wdata;
    logic [DATA_W-1:0]   align_load;
    logic                in_req;
    logic                done;

    // Base plus sign-extended immediate, wrapping modulo 2^ADDR_W.
    assign addr_calc = ADDR_W'(i_rf_rdata1)
                     + {{(ADDR_W-ImmW){i_next_to_execute.imm[ImmW-1]}}, i_next_to_execute.imm};

    assign take        = (state_q == StIdle) && i_want_to_execute && !i_flush;
    assign o_take      = take;
    assign o_rf_raddr1 = i_next_to_execute.src1;
    assign o_rf_raddr2 = i_next_to_execute.src2;

    lsu_data_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_size       (size_q),
        .i_signed     (signed_q),
        .i_addr_lo    (addr_q[LaneW-1:0]),
        .i_store_data (sdata_q),
        .i_load_data  (i_mem_resp_data),
        .o_be         (align_be),
        .o_wdata      (align_wdata),
        .o_load_data  (align_load)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        action_d     = action_q;
        size_d       = size_q;
        signed_d     = signed_q;
        uses_dst_d   = uses_dst_q;
        dst_d        = dst_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        misaligned_d = misaligned_q;
        ldata_d      = ldata_q;

        unique case (state_q)
            StIdle: begin
                if (take) begin
                    pc_d         = i_next_to_execute.pc;
                    action_d     = i_next_to_execute.mem_action;
                    size_d       = i_next_to_execute.mem_size;
                    signed_d     = i_next_to_execute.mem_signed;
                    uses_dst_d   = i_next_to_execute.uses_dst;
                    dst_d        = i_next_to_execute.dst;
                    addr_d       = addr_calc;
                    sdata_d      = i_rf_rdata2;
                    misaligned_d = is_misaligned(i_next_to_execute.mem_size, addr_calc[1:0]);
                    state_d      = misaligned_d ? StDone : StReq;
                end
            end
            StReq: begin
                if (i_flush) begin
                    state_d = StIdle;
                end else if (i_mem_req_ready) begin
                    state_d = (action_q == MemWrite) ? StDone : StWait;
                end
            end
            StWait: begin
                // The cache still owes a response; DRAIN swallows it after a flush.
                if (i_flush) begin
                    state_d = StDrain;
                end else if (i_mem_resp_valid) begin
                    ldata_d = align_load;
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            StDrain: begin
                if (i_mem_resp_valid) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= '0;
            action_q     <= MemRead;
            size_q       <= MemByte;
            signed_q     <= 1'b0;
            uses_dst_q   <= 1'b0;
            dst_q        <= '0;
            addr_q       <= '0;
            sdata_q      <= '0;
            misaligned_q <= 1'b0;
            ldata_q      <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            action_q     <= action_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            uses_dst_q   <= uses_dst_d;
            dst_q        <= dst_d;
            addr_q       <= addr_d;
            sdata_q      <= sdata_d;
            misaligned_q <= misaligned_d;
            ldata_q      <= ldata_d;
        end
    end

    // Request payload is driven only in REQ so idle outputs read as zero; valid alone is
    // masked by flush so no handshake can complete in the flush cycle.
    always_comb begin
        in_req          = (state_q == StReq);
        o_mem_req_valid = in_req && !i_flush;
        o_mem_req_write = in_req && (action_q == MemWrite);
        o_mem_req_addr  = in_req ? {addr_q[ADDR_W-1:LaneW], LaneW'(0)} : '0;
        o_mem_req_wdata = in_req ? align_wdata : '0;
        o_mem_req_be    = in_req ? align_be : '0;

        done              = (state_q == StDone) && !i_flush;
        o_done_valid      = done;
        o_done_pc         = done ? ADDR_W'(pc_q) : '0;
        o_done_misaligned = done && misaligned_q;
        o_wb_valid        = done && !misaligned_q && (action_q == MemRead) && uses_dst_q;
        o_wb_dst          = o_wb_valid ? dst_q : '0;
        o_wb_data         = o_wb_valid ? ldata_q : '0;

        o_busy = (state_q != StIdle);
    end

endmodule

// File: tb/tb_load_store_execution_unit.sv
module tb_load_store_execution_unit;
    import load_store_execution_unit_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             want;
    scheduler_entry_t entry;
    logic             take;
    logic [PregW-1:0] raddr1, raddr2;
    logic [31:0]      rdata1, rdata2;
    logic             req_valid, req_ready, req_write;
    logic [31:0]      req_addr, req_wdata;
    logic [3:0]       req_be;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic             wb_valid;
    logic [PregW-1:0] wb_dst;
    logic [31:0]      wb_data;
    logic             done_valid;
    logic [31:0]      done_pc;
    logic             done_mis;
    logic             busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_execution_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_flush           (flush),
        .i_want_to_execute (want),
        .i_next_to_execute (entry),
        .o_take            (take),
        .o_rf_raddr1       (raddr1),
        .o_rf_raddr2       (raddr2),
        .i_rf_rdata1       (rdata1),
        .i_rf_rdata2       (rdata2),
        .o_mem_req_valid   (req_valid),
        .i_mem_req_ready   (req_ready),
        .o_mem_req_write   (req_write),
        .o_mem_req_addr    (req_addr),
        .o_mem_req_wdata   (req_wdata),
        .o_mem_req_be      (req_be),
        .i_mem_resp_valid  (resp_valid),
        .i_mem_resp_data   (resp_data),
        .o_wb_valid        (wb_valid),
        .o_wb_dst          (wb_dst),
        .o_wb_data         (wb_data),
        .o_done_valid      (done_valid),
        .o_done_pc         (done_pc),
        .o_done_misaligned (done_mis),
        .o_busy            (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are checked at +5 (falling).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (access rules, plain arithmetic) ----------------
    function automatic logic [31:0] m_addr(input logic [31:0] base, input logic [11:0] imm);
        int simm;
        simm = int'($signed(imm));
        return base + simm;
    endfunction

    function automatic int m_nbytes(input mem_size_t s);
        if (s == MemByte) return 1;
        if (s == MemHalf) return 2;
        return 4;
    endfunction

    function automatic logic [3:0] m_be(input int nb, input int lo);
        int v;
        v = ((1 << nb) - 1) << lo;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input int nb, input logic [31:0] d);
        if (nb == 1) return {24'b0, d[7:0]} * 32'h0101_0101;
        if (nb == 2) return {16'b0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] resp, input int lo, input int nb,
                                           input logic sgn);
        logic [31:0] v;
        v = resp >> (8 * lo);
        if (nb == 1) return sgn ? int'($signed(v[7:0])) : {24'b0, v[7:0]};
        if (nb == 2) return sgn ? int'($signed(v[15:0])) : {16'b0, v[15:0]};
        return v;
    endfunction

    function automatic scheduler_entry_t rand_entry();
        scheduler_entry_t e;
        e.pc         = $urandom & 32'hFFFF_FFFC;
        e.mem_action = mem_action_t'($urandom_range(0, 1));
        e.mem_size   = mem_size_t'($urandom_range(0, 2));
        e.mem_signed = 1'($urandom_range(0, 1));
        e.uses_dst   = 1'($urandom_range(0, 1));
        e.dst        = PregW'($urandom);
        e.src1       = PregW'($urandom);
        e.src2       = PregW'($urandom);
        e.imm        = 12'($urandom) & 12'hFFC;
        return e;
    endfunction

    // One full instruction from the take cycle through DONE, checked cycle by cycle.
    task automatic do_op(input scheduler_entry_t e, input logic [31:0] base,
                         input logic [31:0] sdata, input logic [31:0] resp,
                         input int rdy_wait, input int resp_wait);
        logic [31:0] a;
        int          nb, lo;
        logic        mis, is_rd, exp_wb;
        a      = m_addr(base, e.imm);
        nb     = m_nbytes(e.mem_size);
        lo     = int'(a[1:0]);
        mis    = (lo % nb) != 0;
        is_rd  = (e.mem_action == MemRead);
        exp_wb = is_rd && !mis && e.uses_dst;

        want = 1'b1; entry = e; rdata1 = base; rdata2 = sdata;
        #4;
        check("take", take, 1);
        check("raddr1", raddr1, e.src1);
        check("raddr2", raddr2, e.src2);
        tick();
        want = 1'b0; rdata1 = $urandom; rdata2 = $urandom;
        if (!mis) begin
            for (int k = 0; k <= rdy_wait; k++) begin
                req_ready  = (k == rdy_wait);
                want       = 1'($urandom_range(0, 1));
                entry      = rand_entry();
                resp_valid = 1'($urandom_range(0, 1));
                resp_data  = $urandom;
                #4;
                check("req_valid", req_valid, 1);
                check("req_write", req_write, !is_rd);
                check("req_addr", req_addr, a & 32'hFFFF_FFFC);
                check("req_be", req_be, m_be(nb, lo));
                if (!is_rd) check("req_wdata", req_wdata, m_wdata(nb, sdata));
                check("take_busy", take, 0);
                check("done_early", done_valid, 0);
                tick();
            end
            req_ready = 1'b0; want = 1'b0; resp_valid = 1'b0;
            if (is_rd) begin
                for (int k = 0; k <= resp_wait; k++) begin
                    resp_valid = (k == resp_wait);
                    resp_data  = (k == resp_wait) ? resp : $urandom;
                    #4;
                    check("wait_req", req_valid, 0);
                    check("wait_done", done_valid, 0);
                    check("wait_wb", wb_valid, 0);
                    tick();
                end
                resp_valid = 1'b0;
                resp_data  = $urandom;
            end
        end
        #4;
        check("done_valid", done_valid, 1);
        check("done_pc", done_pc, e.pc);
        check("done_mis", done_mis, mis);
        check("done_req", req_valid, 0);
        check("wb_valid", wb_valid, exp_wb);
        if (exp_wb) begin
            check("wb_dst", wb_dst, e.dst);
            check("wb_data", wb_data, m_load(resp, lo, nb, e.mem_signed));
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            want = 1'b0;
            #4;
            check("idle_busy", busy, 0);
            check("idle_done", done_valid, 0);
            tick();
        end
    endtask

    function automatic scheduler_entry_t mk(input logic [31:0] pc, input mem_action_t act,
                                            input mem_size_t sz, input logic sgn,
                                            input logic [11:0] imm);
        scheduler_entry_t e;
        e = '0;
        e.pc = pc; e.mem_action = act; e.mem_size = sz; e.mem_signed = sgn;
        e.uses_dst = 1'b1; e.dst = 7; e.src1 = 3; e.src2 = 4; e.imm = imm;
        return e;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        scheduler_entry_t e, e2;
        logic [31:0]      base;
        int               lo;

        rst_n = 1'b0; flush = 1'b0; want = 1'b0; entry = '0; rdata1 = '0; rdata2 = '0;
        req_ready = 1'b0; resp_valid = 1'b0; resp_data = '0;
        tick(); tick();
        #4;
        check("rst_take", take, 0);
        check("rst_req_valid", req_valid, 0);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_mis", done_mis, 0);
        check("rst_busy", busy, 0);
        check("rst_req_addr", req_addr, 0);
        check("rst_req_be", req_be, 0);
        check("rst_req_wdata", req_wdata, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_done_pc", done_pc, 0);
        tick();
        rst_n = 1'b1;
        idle(1);

        // Load word 0x1000+4, zero-wait cache.
        do_op(mk(32'h100, MemRead, MemWord, 1'b0, 12'd4), 32'h1000, 32'h0, 32'hDEAD_BEEF, 0, 0);
        // Byte load at 0x1003, signed then unsigned.
        do_op(mk(32'h104, MemRead, MemByte, 1'b1, 12'd3), 32'h1000, 32'h0, 32'h80FF_FFFF, 0, 0);
        do_op(mk(32'h108, MemRead, MemByte, 1'b0, 12'd3), 32'h1000, 32'h0, 32'h80FF_FFFF, 0, 1);
        // Store half at 0x2002 with ready low for 3 cycles.
        do_op(mk(32'h10C, MemWrite, MemHalf, 1'b0, 12'd2), 32'h2000, 32'h1234_ABCD, 32'h0, 3, 0);
        // Misaligned word at 0x3001; also a negative immediate.
        do_op(mk(32'h110, MemRead, MemWord, 1'b0, 12'd1), 32'h3000, 32'h0, 32'h0, 0, 0);
        do_op(mk(32'h114, MemRead, MemHalf, 1'b1, 12'hFFE), 32'h4000, 32'h0, 32'h0000_8001, 1, 2);
        idle(1);

        // Flush in WAIT, response two cycles later, then the next offer is taken.
        e  = mk(32'h200, MemRead, MemWord, 1'b0, 12'd0);
        e2 = mk(32'h204, MemWrite, MemByte, 1'b0, 12'd1);
        want = 1'b1; entry = e; rdata1 = 32'h5000;
        #4; check("fw_take", take, 1);
        tick(); want = 1'b0; req_ready = 1'b1;
        #4; check("fw_req", req_valid, 1);
        tick(); req_ready = 1'b0; flush = 1'b1;
        #4; check("fw_flush_done", done_valid, 0); check("fw_flush_wb", wb_valid, 0);
        tick(); flush = 1'b0; want = 1'b1; entry = e2;
        #4; check("fw_drain_take", take, 0); check("fw_drain_busy", busy, 1);
        tick(); resp_valid = 1'b1; resp_data = 32'hCAFE_F00D;
        #4; check("fw_drain_take2", take, 0); check("fw_drain_wb", wb_valid, 0);
        check("fw_drain_done", done_valid, 0);
        tick(); resp_valid = 1'b0;
        do_op(e2, 32'h6000, 32'h0000_00A5, 32'h0, 0, 0);

        // Flush together with an offer.
        want = 1'b1; flush = 1'b1; entry = e;
        #4; check("ft_take", take, 0);
        tick(); want = 1'b0; flush = 1'b0;
        #4; check("ft_busy", busy, 0); check("ft_req", req_valid, 0);
        tick();

        // Flush in REQ while the cache is ready.
        want = 1'b1; entry = e; rdata1 = 32'h7000;
        #4; check("fr_take", take, 1);
        tick(); want = 1'b0; req_ready = 1'b1; flush = 1'b1;
        #4; check("fr_req_valid", req_valid, 0);
        tick(); req_ready = 1'b0; flush = 1'b0;
        #4; check("fr_busy", busy, 0); check("fr_done", done_valid, 0);
        check("fr_wb", wb_valid, 0);
        tick();

        // Random traffic; low address bits mostly aligned to the access size.
        for (int n = 0; n < 150; n++) begin
            e    = rand_entry();
            lo   = $urandom_range(0, 3);
            if ($urandom_range(0, 4) != 0) lo = lo - (lo % m_nbytes(e.mem_size));
            base = ($urandom & 32'hFFFF_FFFC) | 32'(lo);
            do_op(e, base, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/load_store_execution_unit.md
# load_store_execution_unit

Consumer end of the load-store queue's issue handshake: accepts one memory instruction at a time when the queue offers it, reads its physical operands, and drives a valid/ready request to the data cache. It waits for load data, aligns and extends it, then writes back the destination physical register. It also signals completion to the commit logic. It sits between the load-store queue, the physical register file, the data cache port and the commit queue.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte lanes = DATA_W/8 (4)
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_flush  in  1  hazard-controller flush
- i_want_to_execute  in  1  queue offers an entry
- i_next_to_execute  in  scheduler_entry_t  offered entry (combinational from queue)
- o_take  out  1  entry accepted this cycle
- o_rf_raddr1 / o_rf_raddr2  out  $clog2(PHYS_REG_COUNT)  = offered src1/src2
- i_rf_rdata1 / i_rf_rdata2  in  DATA_W  combinational register-file read data
- o_mem_req_valid  out  1;  i_mem_req_ready  in  1
- o_mem_req_write  out  1;  o_mem_req_addr  out  ADDR_W (word-aligned);  o_mem_req_wdata  out  DATA_W;  o_mem_req_be  out  4
- i_mem_resp_valid  in  1;  i_mem_resp_data  in  DATA_W  load data for the oldest outstanding read
- o_wb_valid  out  1;  o_wb_dst  out  $clog2(PHYS_REG_COUNT);  o_wb_data  out  DATA_W  (also sets register valid)
- o_done_valid  out  1;  o_done_pc  out  ADDR_W;  o_done_misaligned  out  1
- o_busy  out  1  state != IDLE

## Operation
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - o_take = i_want_to_execute && !i_flush.
  - On take, latch entry fields pc, mem_action, mem_size, mem_signed, uses_dst, dst, and imm.
  - Latch operands rdata1 (base) and rdata2 (store data).
  - Compute addr = rdata1 + sign-extended imm, modulo 2^32.
- Misaligned (HALF with addr[0]=1, WORD with addr[1:0]!=0): go to DONE with o_done_misaligned=1. No memory request, no writeback. Otherwise go to REQ.
- REQ:
  - o_mem_req_valid=1. addr, write, wdata and be are held stable until i_mem_req_ready.
  - On handshake, a WRITE goes to DONE and a READ goes to WAIT.
- Store lanes:
  - BYTE: be = 0001 << addr[1:0], wdata = byte replicated ×4.
  - HALF: be = 0011 << addr[1:0], wdata = half replicated ×2.
  - WORD: be = 1111.
- WAIT: on i_mem_resp_valid, compute shifted = resp >> 8*addr[1:0]. Zero- or sign-extend the low 8 or 16 bits per mem_signed; WORD passes through. Go to DONE.
- DONE: one-cycle pulse of o_done_valid and o_done_pc.
  - o_wb_valid=1 only for a non-misaligned READ with uses_dst.
  - Return to IDLE.
- Flush has priority over every transition:
  - IDLE, REQ and DONE go to IDLE. o_mem_req_valid and o_take are forced to 0 in the flush cycle, so no handshake occurs. o_done_valid and o_wb_valid are suppressed.
  - WAIT goes to DRAIN. DRAIN discards the next i_mem_resp_valid, then goes to IDLE. A flush during DRAIN stays in DRAIN.
- Stores reach this block only when non-speculative; flush never cancels an accepted store.

## Timing
- Reset: state IDLE. o_take, o_mem_req_valid, o_wb_valid, o_done_valid, o_done_misaligned, o_busy = 0. All data outputs = 0.
- o_take is combinational from i_want_to_execute, state and i_flush. Entry and operands are registered at the take edge.
- The queue removes its entry on o_take in the same cycle.
- Minimum latency with zero-wait cache:
  - Store: take cycle T, request T+1, done T+2.
  - Load: request T+1, response T+2 at the earliest, done/wb T+3.
  - Misaligned: done T+1.
- Next take is possible in the cycle after DONE, when state is back in IDLE.
- i_mem_resp_valid outside WAIT/DRAIN is ignored.

## Structure
- Shared package: mem_action_t (READ/WRITE), mem_size_t (BYTE/HALF/WORD), and the scheduler_entry_t fields mem_size, mem_signed and imm added to the entry meta.
- Local enum lsu_state_t.
- One combinational sub-module, lsu_data_align, handles both directions: store be/wdata generation and load shift/extend.

## Test plan
- Load word: base p3=0x1000, imm=4, cache ready and response 1 cycle later with 0xDEADBEEF → req addr 0x1004, be=1111; wb p7=0xDEADBEEF at T+3; done pc matches.
- Signed load byte: addr 0x1003, resp 0x80FFFFFF → o_wb_data=0xFFFFFF80. The same access unsigned gives 0x00000080.
- Store half: addr 0x2002, data 0x1234ABCD, ready held low 3 cycles → req stable for 4 cycles; be=1100, wdata=0xABCDABCD; no wb; done after handshake.
- Misaligned word at 0x3001 → no mem_req_valid; done_misaligned=1 at T+1; no wb.
- Flush while in WAIT, then response 2 cycles later → state DRAIN; no wb/done; o_take=0 until response consumed; next offered entry taken the cycle after.
- Flush in the same cycle as i_want_to_execute and in REQ with ready=1 → o_take=0, no handshake; state returns to IDLE.
